// File: rtl/wb_fml_width_adapter_if.sv
// Wishbone-slave / FML-master bus bundle for the width adapter.
// Latency: none (wires only).
// Backpressure: carried by the signals themselves (wb_ack_o, fml_ack).
// Ports: Wishbone side wb_* (32-bit classic single access), FML side fml_*
// (DDR_DW-bit beats). The 'slave' modport is the adapter's view and the
// 'master' modport is the view of whatever drives Wishbone and answers FML.
interface wb_fml_width_adapter_if #(
    parameter int DDR_DW = 16,
    parameter int ADR_W  = 26
);
    logic [31:0]         wb_adr_i;
    logic [31:0]         wb_dat_i;
    logic [3:0]          wb_sel_i;
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic                wb_we_i;
    logic [2:0]          wb_cti_i;
    logic [31:0]         wb_dat_o;
    logic                wb_ack_o;
    logic                wb_err_o;

    logic [ADR_W-1:0]    fml_adr;
    logic                fml_stb;
    logic                fml_we;
    logic [DDR_DW/8-1:0] fml_sel;
    logic [DDR_DW-1:0]   fml_do;
    logic [DDR_DW-1:0]   fml_di;
    logic                fml_ack;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output fml_adr, fml_stb, fml_we, fml_sel, fml_do,
        input  fml_di, fml_ack
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  fml_adr, fml_stb, fml_we, fml_sel, fml_do,
        output fml_di, fml_ack
    );
endinterface

// File: rtl/wb_fml_width_adapter.sv
// Splits one 32-bit Wishbone access into N = 32/DDR_DW FML beats, MS slice first.
// Latency: wb_ack_o M+1 cycles after accept (M = beats needed) when fml_ack is immediate.
// Backpressure: each beat holds fml_stb and its address/data until fml_ack.
// Ports: sys_clk, sys_rst (async, active-high), bus (slave modport: wb_* and fml_*).
// Optional: define WB_FML_ADAPTER_TIMEOUT_EN for a per-beat watchdog that ends a
// stuck access with a one-cycle wb_err_o after TIMEOUT_CYCLES cycles without fml_ack.
module wb_fml_width_adapter #(
    parameter int DDR_DW         = 16,
    parameter int ADR_W          = 26,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    wb_fml_width_adapter_if.slave  bus
);
    localparam int N  = 32 / DDR_DW;
    localparam int SW = DDR_DW / 8;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t            state_q;
    logic [ADR_W-1:0]  base_q;
    logic [31:0]       wdat_q;
    logic [3:0]        sel_q;
    logic              we_q;
    logic [31:0]       rdat_q;
    logic [KW-1:0]     beat_q;
    logic              abort_q;

    // Cycle-type and the low/high address bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{bus.wb_cti_i, bus.wb_adr_i};

`ifdef WB_FML_ADAPTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
`else
    assign bus.wb_err_o = 1'b0;
`endif

    // Source of the access: the live bus while IDLE (accept cycle), the
    // latched copy afterwards. Next needed beat is searched from from_k up.
    logic              src_we;
    logic [3:0]        src_sel;
    logic [31:0]       src_dat;
    logic [ADR_W-1:0]  src_base;
    int                from_k;
    logic [3:0]        sel_k;
    logic              beat_found_d;
    logic [KW-1:0]     beat_d;
    logic [ADR_W-1:0]  fml_adr_d;
    logic [31:0]       dat_sh;
    logic [3:0]        sel_sh;
    logic [DDR_DW-1:0] fml_do_d;
    logic [SW-1:0]     fml_sel_d;
    logic [31:0]       di_top;
    logic              abort_now;

    always_comb begin
        if (state_q == IDLE) begin
            src_we   = bus.wb_we_i;
            src_sel  = bus.wb_sel_i;
            src_dat  = bus.wb_dat_i;
            src_base = {bus.wb_adr_i[ADR_W-1:2], 2'b00};
            from_k   = 0;
        end else begin
            src_we   = we_q;
            src_sel  = sel_q;
            src_dat  = wdat_q;
            src_base = base_q;
            from_k   = int'(beat_q) + 1;
        end

        // Walk downward so the lowest qualifying beat index wins. Reads need
        // every beat; writes skip beats whose byte enables are all zero.
        beat_found_d = 1'b0;
        beat_d       = '0;
        sel_k        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sel_k = src_sel << (k * SW);
            if (k >= from_k && (!src_we || sel_k[3 -: SW] != '0)) begin
                beat_found_d = 1'b1;
                beat_d       = KW'(k);
            end
        end

        fml_adr_d = src_base + ADR_W'(int'(beat_d) * SW);
        dat_sh    = src_dat << (int'(beat_d) * DDR_DW);
        sel_sh    = src_sel << (int'(beat_d) * SW);
        fml_do_d  = dat_sh[31 -: DDR_DW];
        fml_sel_d = sel_sh[3 -: SW];

        // Read data lands MS-aligned, then shifts down into slice beat_q.
        di_top    = 32'(bus.fml_di) << (32 - DDR_DW);
        abort_now = abort_q | ~bus.wb_cyc_i;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            wdat_q       <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            rdat_q       <= '0;
            beat_q       <= '0;
            abort_q      <= 1'b0;
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= '0;
            bus.fml_stb  <= 1'b0;
            bus.fml_we   <= 1'b0;
            bus.fml_sel  <= '0;
            bus.fml_adr  <= '0;
            bus.fml_do   <= '0;
`ifdef WB_FML_ADAPTER_TIMEOUT_EN
            bus.wb_err_o <= 1'b0;
            tmo_q        <= '0;
`endif
        end else begin
            bus.wb_ack_o <= 1'b0;
`ifdef WB_FML_ADAPTER_TIMEOUT_EN
            bus.wb_err_o <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // The completion cycle still sees the master's old
                    // strobe, so a new access is only taken once it clears.
                    if (bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_ack_o && !bus.wb_err_o) begin
                        base_q     <= src_base;
                        wdat_q     <= src_dat;
                        sel_q      <= src_sel;
                        we_q       <= src_we;
                        rdat_q     <= '0;
                        abort_q    <= 1'b0;
                        bus.fml_we <= src_we;
                        if (beat_found_d) begin
                            state_q     <= BEAT;
                            beat_q      <= beat_d;
                            bus.fml_adr <= fml_adr_d;
                            bus.fml_do  <= fml_do_d;
                            bus.fml_sel <= fml_sel_d;
                            bus.fml_stb <= 1'b1;
`ifdef WB_FML_ADAPTER_TIMEOUT_EN
                            tmo_q       <= '0;
`endif
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                BEAT: begin
                    if (!bus.wb_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                    if (bus.fml_ack) begin
                        if (!we_q) begin
                            rdat_q <= rdat_q | (di_top >> (int'(beat_q) * DDR_DW));
                        end
`ifdef WB_FML_ADAPTER_TIMEOUT_EN
                        tmo_q <= '0;
`endif
                        if (beat_found_d && !abort_now) begin
                            beat_q      <= beat_d;
                            bus.fml_adr <= fml_adr_d;
                            bus.fml_do  <= fml_do_d;
                            bus.fml_sel <= fml_sel_d;
                        end else begin
                            bus.fml_stb <= 1'b0;
                            state_q     <= abort_now ? IDLE : DONE;
                        end
                    end
`ifdef WB_FML_ADAPTER_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        bus.fml_stb  <= 1'b0;
                        bus.wb_err_o <= ~abort_now;
                        state_q      <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    bus.wb_ack_o <= 1'b1;
                    bus.wb_dat_o <= rdat_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_fml_width_adapter.sv
// Bench for wb_fml_width_adapter: a 16-bit and an 8-bit instance, directed
// accesses, FML responders with programmable ack delay, and per-instance
// scoreboards of expected beats and Wishbone completions checked by monitors.
module tb_wb_fml_width_adapter;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    wb_fml_width_adapter_if #(.DDR_DW(16), .ADR_W(26)) ifa ();
    wb_fml_width_adapter_if #(.DDR_DW(8),  .ADR_W(26)) ifb ();

    wb_fml_width_adapter #(.DDR_DW(16), .ADR_W(26), .TIMEOUT_CYCLES(8)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ifa.slave));
    wb_fml_width_adapter #(.DDR_DW(8), .ADR_W(26), .TIMEOUT_CYCLES(8)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ifb.slave));

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;
    typedef struct {
        logic        chk;
        logic [31:0] dat;
    } ack_t;

    beat_t       exp_beats[2][$];
    ack_t        exp_acks[2][$];
    logic [31:0] rd_q[2][$];
    int          ack_delay[2];
    int          wcnt[2];
    int          err_cnt[2];
    bit          hold_chk[2];
    bit          pstb[2];
    bit          pack[2];
    logic [31:0] padr[2];
    logic        force_ack;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input int w, input logic [31:0] adr, input logic we,
                            input logic [3:0] sel, input logic [31:0] dat);
        beat_t e;
        e.adr = adr; e.we = we; e.sel = sel; e.dat = dat;
        exp_beats[w].push_back(e);
    endtask

    task automatic exp_ack(input int w, input logic c, input logic [31:0] dat);
        ack_t e;
        e.chk = c; e.dat = dat;
        exp_acks[w].push_back(e);
    endtask

    task automatic mon_beat(input int w, input logic [31:0] adr, input logic we,
                            input logic [3:0] sel, input logic [31:0] dat);
        beat_t e;
        if (exp_beats[w].size() == 0) begin
            tests++; fails++;
            $display("FAIL beat_unexpected dut%0d: got beat at adr %h expected none", w, adr);
        end else begin
            e = exp_beats[w].pop_front();
            chk($sformatf("beat_adr dut%0d", w), adr, e.adr);
            chk($sformatf("beat_we dut%0d", w), 32'(we), 32'(e.we));
            chk($sformatf("beat_sel dut%0d", w), 32'(sel), 32'(e.sel));
            if (e.we) chk($sformatf("beat_do dut%0d", w), dat, e.dat);
        end
    endtask

    task automatic mon_ack(input int w, input logic [31:0] dat);
        ack_t e;
        tests++;
        if (exp_acks[w].size() == 0) begin
            fails++;
            $display("FAIL ack_unexpected dut%0d: got wb_ack_o dat %h expected no ack", w, dat);
        end else begin
            e = exp_acks[w].pop_front();
            if (e.chk) chk($sformatf("wb_dat dut%0d", w), dat, e.dat);
        end
    endtask

    // FML responders: answer a beat after ack_delay waiting cycles.
    always @(posedge sys_clk) begin
        #1;
        if (sys_rst || !ifa.fml_stb) begin
            ifa.fml_ack = force_ack; wcnt[0] = 0;
        end else if (wcnt[0] == ack_delay[0]) begin
            ifa.fml_ack = 1'b1; wcnt[0] = 0;
            ifa.fml_di = (rd_q[0].size() != 0) ? 16'(rd_q[0].pop_front()) : 16'h0;
        end else begin
            ifa.fml_ack = 1'b0; wcnt[0]++;
        end
    end

    always @(posedge sys_clk) begin
        #1;
        if (sys_rst || !ifb.fml_stb) begin
            ifb.fml_ack = force_ack; wcnt[1] = 0;
        end else if (wcnt[1] == ack_delay[1]) begin
            ifb.fml_ack = 1'b1; wcnt[1] = 0;
            ifb.fml_di = (rd_q[1].size() != 0) ? 8'(rd_q[1].pop_front()) : 8'h0;
        end else begin
            ifb.fml_ack = 1'b0; wcnt[1]++;
        end
    end

    // Monitors sample on the falling edge.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (ifa.fml_stb && ifa.fml_ack)
                mon_beat(0, 32'(ifa.fml_adr), ifa.fml_we, 4'(ifa.fml_sel), 32'(ifa.fml_do));
            if (hold_chk[0] && pstb[0] && !pack[0]) begin
                chk("hold_stb dut0", 32'(ifa.fml_stb), 32'd1);
                chk("hold_adr dut0", 32'(ifa.fml_adr), padr[0]);
            end
            if (ifa.wb_ack_o) mon_ack(0, ifa.wb_dat_o);
            if (ifa.wb_err_o) err_cnt[0]++;
        end
        pstb[0] = ifa.fml_stb; pack[0] = ifa.fml_ack; padr[0] = 32'(ifa.fml_adr);
    end

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (ifb.fml_stb && ifb.fml_ack)
                mon_beat(1, 32'(ifb.fml_adr), ifb.fml_we, 4'(ifb.fml_sel), 32'(ifb.fml_do));
            if (hold_chk[1] && pstb[1] && !pack[1]) begin
                chk("hold_stb dut1", 32'(ifb.fml_stb), 32'd1);
                chk("hold_adr dut1", 32'(ifb.fml_adr), padr[1]);
            end
            if (ifb.wb_ack_o) mon_ack(1, ifb.wb_dat_o);
            if (ifb.wb_err_o) err_cnt[1]++;
        end
        pstb[1] = ifb.fml_stb; pack[1] = ifb.fml_ack; padr[1] = 32'(ifb.fml_adr);
    end

    task automatic drive(input int w, input logic c, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic we);
        if (w == 0) begin
            ifa.wb_cyc_i = c; ifa.wb_stb_i = c; ifa.wb_adr_i = adr;
            ifa.wb_dat_i = dat; ifa.wb_sel_i = sel; ifa.wb_we_i = we;
        end else begin
            ifb.wb_cyc_i = c; ifb.wb_stb_i = c; ifb.wb_adr_i = adr;
            ifb.wb_dat_i = dat; ifb.wb_sel_i = sel; ifb.wb_we_i = we;
        end
    endtask

    function automatic logic done_seen(input int w);
        return (w == 0) ? (ifa.wb_ack_o | ifa.wb_err_o) : (ifb.wb_ack_o | ifb.wb_err_o);
    endfunction

    // One Wishbone access; exp_lat < 0 skips the latency check.
    task automatic req(input int w, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we, input int exp_lat);
        int n;
        bit done;
        repeat (2) @(negedge sys_clk);
        drive(w, 1'b1, adr, dat, sel, we);
        n = 0; done = 0;
        while (!done && n < 300) begin
            @(posedge sys_clk); #1;
            n++;
            if (done_seen(w)) done = 1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL req_wait dut%0d adr %h: got no completion in %0d cycles expected one", w, adr, n);
        end else if (exp_lat >= 0) begin
            chk($sformatf("latency dut%0d adr %h", w, adr), 32'(n - 1), 32'(exp_lat));
        end
        drive(w, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        force_ack = 1'b0;
        ack_delay[0] = 0; ack_delay[1] = 0;
        err_cnt[0] = 0;   err_cnt[1] = 0;
        hold_chk[0] = 1;  hold_chk[1] = 1;
        ifa.wb_cti_i = 3'b000; ifb.wb_cti_i = 3'b000;
        ifa.fml_ack = 1'b0; ifa.fml_di = '0; ifb.fml_ack = 1'b0; ifb.fml_di = '0;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Reset values.
        #23;
        chk("rst_stb_a",  32'(ifa.fml_stb), 32'd0);
        chk("rst_ack_a",  32'(ifa.wb_ack_o), 32'd0);
        chk("rst_err_a",  32'(ifa.wb_err_o), 32'd0);
        chk("rst_dat_a",  ifa.wb_dat_o, 32'd0);
        chk("rst_fml_a",  {ifa.fml_we, ifa.fml_sel, ifa.fml_do, 10'h0}, 32'd0);
        chk("rst_adr_a",  32'(ifa.fml_adr), 32'd0);
        chk("rst_stb_b",  32'(ifb.fml_stb), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // 16-bit read, immediate ack.
        rd_q[0].push_back(32'hDEAD); rd_q[0].push_back(32'hBEEF);
        exp_beat(0, 32'h100, 1'b0, 4'b0011, 32'h0);
        exp_beat(0, 32'h102, 1'b0, 4'b0011, 32'h0);
        exp_ack(0, 1'b1, 32'hDEADBEEF);
        req(0, 32'h100, 32'h0, 4'hF, 1'b0, 3);

        // 16-bit full write.
        exp_beat(0, 32'h204, 1'b1, 4'b0011, 32'hCAFE);
        exp_beat(0, 32'h206, 1'b1, 4'b0011, 32'hF00D);
        exp_ack(0, 1'b0, 32'h0);
        req(0, 32'h204, 32'hCAFEF00D, 4'hF, 1'b1, 3);

        // Low-half write; address bits [1:0] ignored.
        exp_beat(0, 32'h12, 1'b1, 4'b0011, 32'h5678);
        exp_ack(0, 1'b0, 32'h0);
        req(0, 32'h13, 32'h12345678, 4'b0011, 1'b1, 2);

        // Single top byte write.
        exp_beat(0, 32'h10, 1'b1, 4'b0010, 32'h1234);
        exp_ack(0, 1'b0, 32'h0);
        req(0, 32'h10, 32'h12345678, 4'b1000, 1'b1, 2);

        // Write with no byte enables: no beat at all.
        exp_ack(0, 1'b0, 32'h0);
        req(0, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1, 1);

        // Read with 5-cycle ack delay, upper address bits beyond ADR_W dropped.
        ack_delay[0] = 5;
        rd_q[0].push_back(32'h0123); rd_q[0].push_back(32'h4567);
        exp_beat(0, 32'h3FC, 1'b0, 4'b0011, 32'h0);
        exp_beat(0, 32'h3FE, 1'b0, 4'b0011, 32'h0);
        exp_ack(0, 1'b1, 32'h01234567);
        req(0, 32'hFC0003FC, 32'h0, 4'hF, 1'b0, 13);
        ack_delay[0] = 0;

        // Read with partial sel still fetches every beat.
        rd_q[0].push_back(32'hAAAA); rd_q[0].push_back(32'h5555);
        exp_beat(0, 32'h20, 1'b0, 4'b0000, 32'h0);
        exp_beat(0, 32'h22, 1'b0, 4'b0001, 32'h0);
        exp_ack(0, 1'b1, 32'hAAAA5555);
        req(0, 32'h20, 32'h0, 4'b0001, 1'b0, 3);

        // wb_cyc_i dropped mid-beat: that beat finishes, nothing else, no ack.
        ack_delay[0] = 3;
        rd_q[0].push_back(32'h7777);
        exp_beat(0, 32'h600, 1'b0, 4'b0011, 32'h0);
        repeat (2) @(negedge sys_clk);
        drive(0, 1'b1, 32'h600, 32'h0, 4'hF, 1'b0);
        @(posedge sys_clk); #1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (15) @(negedge sys_clk);
        chk("abort_stb", 32'(ifa.fml_stb), 32'd0);
        chk("abort_beats_left", 32'(exp_beats[0].size()), 32'd0);
        rd_q[0].delete();

        // Reset pulse during beat 1.
        rd_q[0].push_back(32'h1111); rd_q[0].push_back(32'h2222);
        exp_beat(0, 32'h500, 1'b0, 4'b0011, 32'h0);
        repeat (2) @(negedge sys_clk);
        drive(0, 1'b1, 32'h500, 32'h0, 4'hF, 1'b0);
        n = 0;
        while (n < 100 && !(ifa.fml_stb && ifa.fml_adr == 26'h502)) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk("rst_reach_beat1", 32'(ifa.fml_stb && ifa.fml_adr == 26'h502), 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        chk("rst_mid_stb", 32'(ifa.fml_stb), 32'd0);
        chk("rst_mid_ack", 32'(ifa.wb_ack_o), 32'd0);
        chk("rst_mid_adr", 32'(ifa.fml_adr), 32'd0);
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        rd_q[0].delete();
        ack_delay[0] = 0;
        repeat (5) @(negedge sys_clk);
        rd_q[0].push_back(32'h5555); rd_q[0].push_back(32'h6666);
        exp_beat(0, 32'h504, 1'b0, 4'b0011, 32'h0);
        exp_beat(0, 32'h506, 1'b0, 4'b0011, 32'h0);
        exp_ack(0, 1'b1, 32'h55556666);
        req(0, 32'h504, 32'h0, 4'hF, 1'b0, 3);

        // fml_ack while idle is ignored.
        repeat (2) @(negedge sys_clk);
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk); #2;
            chk("idle_ack_stb", 32'(ifa.fml_stb), 32'd0);
            chk("idle_ack_wb", 32'(ifa.wb_ack_o | ifb.wb_ack_o), 32'd0);
        end
        force_ack = 1'b0;

        // 8-bit instance: sparse write then full read.
        exp_beat(1, 32'h41, 1'b1, 4'b0001, 32'h22);
        exp_beat(1, 32'h43, 1'b1, 4'b0001, 32'h44);
        exp_ack(1, 1'b0, 32'h0);
        req(1, 32'h40, 32'h11223344, 4'b0101, 1'b1, 3);

        rd_q[1].push_back(32'hAA); rd_q[1].push_back(32'hBB);
        rd_q[1].push_back(32'hCC); rd_q[1].push_back(32'hDD);
        for (int k = 0; k < 4; k++) exp_beat(1, 32'h80 + 32'(k), 1'b0, 4'b0001, 32'h0);
        exp_ack(1, 1'b1, 32'hAABBCCDD);
        req(1, 32'h80, 32'h0, 4'hF, 1'b0, 5);

`ifdef WB_FML_ADAPTER_TIMEOUT_EN
        // Never acked: one error pulse, no ack, back to idle.
        hold_chk[0] = 0;
        ack_delay[0] = 1000;
        req(0, 32'h700, 32'h0, 4'hF, 1'b0, -1);
        repeat (10) @(negedge sys_clk);
        chk("tmo_stb", 32'(ifa.fml_stb), 32'd0);
        chk("tmo_err_low", 32'(ifa.wb_err_o), 32'd0);
        chk("tmo_err_pulses", 32'(err_cnt[0]), 32'd1);
        ack_delay[0] = 0;
        hold_chk[0] = 1;
        rd_q[0].push_back(32'h0A0B); rd_q[0].push_back(32'h0C0D);
        exp_beat(0, 32'h704, 1'b0, 4'b0011, 32'h0);
        exp_beat(0, 32'h706, 1'b0, 4'b0011, 32'h0);
        exp_ack(0, 1'b1, 32'h0A0B0C0D);
        req(0, 32'h704, 32'h0, 4'hF, 1'b0, 3);
`else
        chk("no_err_a", 32'(err_cnt[0]), 32'd0);
`endif

        repeat (5) @(negedge sys_clk);
        chk("beats_left_a", 32'(exp_beats[0].size()), 32'd0);
        chk("acks_left_a",  32'(exp_acks[0].size()), 32'd0);
        chk("beats_left_b", 32'(exp_beats[1].size()), 32'd0);
        chk("acks_left_b",  32'(exp_acks[1].size()), 32'd0);
        chk("no_err_b",     32'(err_cnt[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
